// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 DIF single-path delay-feedback FFT stage with ready/valid stall and self-timed drain.
// Optional define SDF_ROUND_EN: round-half-up on twiddle products (default: arithmetic-shift truncation).
module sdf_r2_stage #(
  parameter int DEPTH = 8,
  parameter int DW    = 14,
  parameter int TW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_in_r,
  input  logic [DW-1:0] data_in_i,
  output logic          valid_o,
  output logic [DW:0]   data_out_r,
  output logic [DW:0]   data_out_i
);

  localparam int KW = $clog2(DEPTH);
  localparam int CW = KW + 1;
  localparam int PW = DW + TW + 2;
  localparam logic [KW-1:0] KMAX = KW'(DEPTH - 1);
  localparam real PI = 3.14159265358979323846;
  localparam real SC = 2.0 ** (TW - 2);
`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 3);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // twiddle ROM W_{2*DEPTH}^k = cos - j*sin, scaled by 2^(TW-2)
  logic [DEPTH-1:0][TW-1:0] rom_r, rom_i;
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam int CR = rnd($cos(PI * g / DEPTH) * SC);
    localparam int CI = rnd(-$sin(PI * g / DEPTH) * SC);
    assign rom_r[g] = TW'(CR);
    assign rom_i[g] = TW'(CI);
  end

  typedef enum logic [1:0] {S_FILL, S_BFLY, S_DRAIN} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] dcnt;
  logic          pend, ready;

  logic                 adv1, bf1, em1;
  logic [KW-1:0]        k1;
  logic signed [DW-1:0] x1r, x1i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
      cnt   <= '0;
      dcnt  <= '0;
      pend  <= 1'b0;
      ready <= 1'b1;
      adv1  <= 1'b0;
      bf1   <= 1'b0;
      em1   <= 1'b0;
      k1    <= '0;
      x1r   <= '0;
      x1i   <= '0;
    end else begin
      adv1 <= 1'b0;
      case (state)
        S_FILL: begin
          if (valid_i) begin
            adv1 <= 1'b1;
            bf1  <= 1'b0;
            em1  <= pend;
            k1   <= cnt[KW-1:0];
            x1r  <= data_in_r;
            x1i  <= data_in_i;
            cnt  <= cnt + 1'b1;
            if (cnt[KW-1:0] == KMAX) begin
              state <= S_BFLY;
              pend  <= 1'b0;
            end
          end else if (pend && cnt == '0) begin
            // first drain step happens on the entry edge so output stays contiguous
            adv1  <= 1'b1;
            bf1   <= 1'b0;
            em1   <= 1'b1;
            k1    <= '0;
            x1r   <= '0;
            x1i   <= '0;
            dcnt  <= KW'(1);
            ready <= 1'b0;
            state <= S_DRAIN;
          end
        end
        S_BFLY: begin
          if (valid_i) begin
            adv1 <= 1'b1;
            bf1  <= 1'b1;
            em1  <= 1'b1;
            k1   <= cnt[KW-1:0];
            x1r  <= data_in_r;
            x1i  <= data_in_i;
            cnt  <= cnt + 1'b1;
            if (cnt[KW-1:0] == KMAX) begin
              state <= S_FILL;
              pend  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (dcnt != '0) begin
            adv1 <= 1'b1;
            bf1  <= 1'b0;
            em1  <= 1'b1;
            k1   <= dcnt;
            x1r  <= '0;
            x1i  <= '0;
            dcnt <= dcnt + 1'b1;
          end else begin
            state <= S_FILL;
            pend  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign ready_o = ready;

  // delay line holds fill inputs, then butterfly differences
  logic signed [DW:0] dl_r [DEPTH];
  logic signed [DW:0] dl_i [DEPTH];
  logic signed [DW:0] a_r, a_i, b_r, b_i;
  assign a_r = dl_r[DEPTH-1];
  assign a_i = dl_i[DEPTH-1];
  assign b_r = (DW+1)'(x1r);
  assign b_i = (DW+1)'(x1i);

  always_ff @(posedge clk) begin
    if (adv1) begin
      dl_r[0] <= bf1 ? a_r - b_r : b_r;
      dl_i[0] <= bf1 ? a_i - b_i : b_i;
      for (int j = 1; j < DEPTH; j++) begin
        dl_r[j] <= dl_r[j-1];
        dl_i[j] <= dl_i[j-1];
      end
    end
  end

  logic [3:1]         vld_pipe;
  logic               tw2, tw3;
  logic [KW-1:0]      k2;
  logic signed [DW:0] v2r, v2i, s3r, s3i;
  logic signed [PW-1:0] p3r, p3i;

  logic signed [TW-1:0] wr, wi;
  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x, mr, mi, rr, ri;
  assign wr   = rom_r[k2];
  assign wi   = rom_i[k2];
  assign ar_x = PW'(v2r);
  assign ai_x = PW'(v2i);
  assign wr_x = PW'(wr);
  assign wi_x = PW'(wi);
  assign mr   = ar_x * wr_x - ai_x * wi_x;
  assign mi   = ar_x * wi_x + ai_x * wr_x;
  assign rr   = p3r + RND;
  assign ri   = p3i + RND;

  logic unused_ok;
  assign unused_ok = ^{rr[PW-1:DW+TW-1], ri[PW-1:DW+TW-1], rr[TW-3:0], ri[TW-3:0]};

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[2:1], adv1 & (bf1 | em1)};
  end

  always_ff @(posedge clk) begin
    if (adv1) begin
      tw2 <= ~bf1;
      k2  <= k1;
      v2r <= bf1 ? a_r + b_r : a_r;
      v2i <= bf1 ? a_i + b_i : a_i;
    end
    tw3 <= tw2;
    s3r <= v2r;
    s3i <= v2i;
    p3r <= mr;
    p3i <= mi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
      data_out_i <= '0;
    end else if (vld_pipe[2]) begin
      data_out_r <= tw3 ? rr[TW-2 +: DW+1] : s3r;
      data_out_i <= tw3 ? ri[TW-2 +: DW+1] : s3i;
    end
  end

  assign valid_o = vld_pipe[3];

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed self-checking bench for sdf_r2_stage at DEPTH=4, DW=14, TW=8.
module tb_sdf_r2_stage;
  localparam int DEPTH = 4;
  localparam int DW    = 14;
  localparam int TW    = 8;

  logic          clk = 1'b0;
  logic          rst, valid_i, ready_o, valid_o;
  logic [DW-1:0] data_in_r, data_in_i;
  logic [DW:0]   data_out_r, data_out_i;

  int total = 0, bad = 0, cyc = 0, rdy_low = 0;
  int q_r[$], q_i[$], q_c[$];

  sdf_r2_stage #(.DEPTH(DEPTH), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      q_r.push_back(int'($signed(data_out_r)));
      q_i.push_back(int'($signed(data_out_i)));
      q_c.push_back(cyc);
    end
    if (ready_o === 1'b0) rdy_low++;
  end

  task automatic drive(input logic v, input int r, input int i);
    valid_i   = v;
    data_in_r = DW'(r);
    data_in_i = DW'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 0, 0);
  endtask

  task automatic clear();
    q_r.delete();
    q_i.delete();
    q_c.delete();
    rdy_low = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset valid_o got=%b want=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset ready_o got=%b want=1", ready_o); end
    total++; if (data_out_r !== '0) begin bad++; $display("FAIL reset data_out_r got=%0d want=0", data_out_r); end
    total++; if (data_out_i !== '0) begin bad++; $display("FAIL reset data_out_i got=%0d want=0", data_out_i); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_impulse();
    int er[8] = '{100, 0, 0, 0, 100, 0, 0, 0};
    clear();
    drive(1'b1, 100, 0);
    for (int n = 1; n < 8; n++) drive(1'b1, 0, 0);
    idle(20);
    total++; if (rdy_low != 4) begin bad++; $display("FAIL impulse drain_ready_low got=%0d want=4", rdy_low); end
    total++; if (q_r.size() != 8) begin bad++; $display("FAIL impulse count got=%0d want=8", q_r.size()); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== 0) begin
        bad++; $display("FAIL impulse out%0d got=(%0d,%0d) want=(%0d,0)", n, q_r[n], q_i[n], er[n]);
      end
    end
  endtask

  task automatic test_const();
    int er[8] = '{100, 100, 100, 100, 0, 0, 0, 0};
    clear();
    for (int n = 0; n < 8; n++) drive(1'b1, 50, 0);
    idle(20);
    total++; if (q_r.size() != 8) begin bad++; $display("FAIL const count got=%0d want=8", q_r.size()); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== 0) begin
        bad++; $display("FAIL const out%0d got=(%0d,%0d) want=(%0d,0)", n, q_r[n], q_i[n], er[n]);
      end
    end
  endtask

  task automatic test_twiddle();
    int er[8] = '{0, 64, 0, 0, 0, 45, 0, 0};
    int ei[8] = '{0, 0, 0, 0, 0, -45, 0, 0};
    clear();
    for (int n = 0; n < 8; n++) drive(1'b1, (n == 1) ? 64 : 0, 0);
    idle(20);
    total++; if (q_r.size() != 8) begin bad++; $display("FAIL twiddle count got=%0d want=8", q_r.size()); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== ei[n]) begin
        bad++; $display("FAIL twiddle out%0d got=(%0d,%0d) want=(%0d,%0d)", n, q_r[n], q_i[n], er[n], ei[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int er[16] = '{100, 0, 0, 0, 100, 0, 0, 0, 0, 64, 0, 0, 0, 45, 0, 0};
    int ei[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -45, 0, 0};
    int e5 = 0;
    clear();
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, (n == 0) ? 100 : ((n == 9) ? 64 : 0), 0);
      if (n == 4) e5 = cyc;
    end
    total++; if (rdy_low != 0) begin bad++; $display("FAIL b2b ready_drop got=%0d want=0", rdy_low); end
    idle(20);
    total++; if (rdy_low != 4) begin bad++; $display("FAIL b2b drain_ready_low got=%0d want=4", rdy_low); end
    total++; if (q_r.size() != 16) begin bad++; $display("FAIL b2b count got=%0d want=16", q_r.size()); end
    total++;
    if (q_c.size() < 16 || q_c[0] != e5 + 3 || q_c[15] != e5 + 18) begin
      bad++; $display("FAIL b2b timing got first=%0d last=%0d want first=%0d last=%0d",
                      (q_c.size() > 0) ? q_c[0] : -1, (q_c.size() > 15) ? q_c[15] : -1, e5 + 3, e5 + 18);
    end
    for (int n = 0; n < 16; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== ei[n]) begin
        bad++; $display("FAIL b2b out%0d got=(%0d,%0d) want=(%0d,%0d)", n, q_r[n], q_i[n], er[n], ei[n]);
      end
    end
  endtask

  task automatic test_gaps();
    int er[8] = '{100, 0, 0, 0, 100, 0, 0, 0};
    clear();
    drive(1'b1, 100, 0);
    drive(1'b1, 0, 0);
    idle(3);
    for (int n = 0; n < 4; n++) drive(1'b1, 0, 0);
    total++; if (rdy_low != 0) begin bad++; $display("FAIL gaps ready_drop got=%0d want=0", rdy_low); end
    idle(3);
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);
    idle(20);
    total++; if (q_r.size() != 8) begin bad++; $display("FAIL gaps count got=%0d want=8", q_r.size()); end
    total++;
    if (q_c.size() < 3 || q_c[1] - q_c[0] != 1 || q_c[2] - q_c[1] != 4) begin
      bad++; $display("FAIL gaps spacing got=%0d,%0d want=1,4",
                      (q_c.size() > 1) ? q_c[1] - q_c[0] : -1, (q_c.size() > 2) ? q_c[2] - q_c[1] : -1);
    end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== 0) begin
        bad++; $display("FAIL gaps out%0d got=(%0d,%0d) want=(%0d,0)", n, q_r[n], q_i[n], er[n]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int er[8] = '{100, 0, 0, 0, 100, 0, 0, 0};
    clear();
    drive(1'b1, 77, 5);
    for (int n = 1; n < 5; n++) drive(1'b1, 33, -9);
    rst = 1'b1;
    drive(1'b0, 0, 0);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst valid_o got=%b want=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL midrst ready_o got=%b want=1", ready_o); end
    rst = 1'b0;
    idle(4);
    total++; if (q_r.size() != 0) begin bad++; $display("FAIL midrst flushed got=%0d want=0", q_r.size()); end
    clear();
    drive(1'b1, 100, 0);
    for (int n = 1; n < 8; n++) drive(1'b1, 0, 0);
    idle(20);
    total++; if (q_r.size() != 8) begin bad++; $display("FAIL midrst count got=%0d want=8", q_r.size()); end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n >= q_r.size() || q_r[n] !== er[n] || q_i[n] !== 0) begin
        bad++; $display("FAIL midrst out%0d got=(%0d,%0d) want=(%0d,0)", n, q_r[n], q_i[n], er[n]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    test_reset();
    test_impulse();
    test_const();
    test_twiddle();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
